// File: rtl/instr_prefetch_queue_pkg.sv
// ============================================================================
//  Module   : instr_prefetch_queue_pkg
//  Purpose  : Shared types and constants for the instruction prefetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ifq_state_t;

    localparam int WORD_BYTES = 4;

    // Width needed to hold a fill level of 0..depth inclusive.
    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ============================================================================
//  Module   : ifq_fifo
//  Purpose  : DEPTH-entry FIFO of {pc, instr}; clear overrides push and pop.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifq_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = ifq_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      mem_q [DEPTH];
    logic [63:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign push_en = push_i && !clear_i;
    assign pop_en  = pop_i && !clear_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
// ============================================================================
//  Module   : instr_prefetch_queue
//  Purpose  : Credit-limited instruction prefetcher with redirect flush.
//             Define IFQ_PERF_CNT_EN to add fetch/flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    localparam int              CNT_W   = ifq_cnt_w(DEPTH);
    localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]     PC_STEP = 32'(WORD_BYTES);

    ifq_state_t       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] drain_cnt;
    logic [31:0]      redirect_pc;
    logic             rsp_valid;
    logic             grant;
    logic             fifo_push;
    logic             fifo_clear;
    logic             fifo_pop;
    logic             rsp_drop;

    assign redirect_pc = redirect_pc_i & ~32'h3;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_valid   = mem_rvalid_i && (outstanding_q != '0);
    assign drain_cnt   = outstanding_q - CNT_W'(rsp_valid);

    assign mem_req_o     = (state_q == RUN) && !redirect_i &&
                           (({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_W);
    assign grant         = mem_req_o && mem_gnt_i;
    assign mem_addr_o    = fetch_pc_q;
    assign instr_valid_o = (fifo_count != '0);
    assign fifo_pop      = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifo_push     = 1'b0;
        fifo_clear    = 1'b0;
        rsp_drop      = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    resp_pc_d  = redirect_pc;
                end
            end
            default: begin
                if (redirect_i) begin
                    // Everything still in flight belongs to the old stream.
                    fifo_clear    = 1'b1;
                    fetch_pc_d    = redirect_pc;
                    resp_pc_d     = redirect_pc;
                    outstanding_d = drain_cnt;
                    discard_d     = drain_cnt;
                    rsp_drop      = rsp_valid;
                    state_d       = (drain_cnt != '0) ? FLUSH : RUN;
                end else if (state_q == FLUSH) begin
                    if (rsp_valid) begin
                        rsp_drop      = 1'b1;
                        discard_d     = discard_q - 1'b1;
                        outstanding_d = outstanding_q - 1'b1;
                        if (discard_q == CNT_W'(1)) begin
                            state_d = RUN;
                        end
                    end
                end else begin
                    if (grant) begin
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end
                    if (rsp_valid) begin
                        fifo_push = 1'b1;
                        resp_pc_d = resp_pc_q + PC_STEP;
                    end
                    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_valid);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .wdata_i ({resp_pc_q, mem_rdata_i}),
        .rdata_o ({instr_pc_o, instr_o}),
        .count_o (fifo_count)
    );

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(grant);
        perf_flush_d = perf_flush_q + 32'(rsp_drop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    logic unused_drop;
    assign unused_drop = rsp_drop;
`endif

`ifndef SYNTHESIS
    a_no_orphan_rvalid : assert property (@(posedge clk_i) disable iff (!rst_i)
        !(mem_rvalid_i && (outstanding_q == '0)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
// ============================================================================
//  Module   : tb_instr_prefetch_queue
//  Purpose  : Self-checking bench: memory model, scoreboard, vector table.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    always #5 clk = ~clk;

    instr_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        logic        stale;
    } pend_t;

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pending[$];
    logic [31:0] expq[$];
    logic [31:0] got_pc[$];
    vec_t        tbl[10];

    int          cyc, lat, n_chk, n_fail, grants, grants_since_rst, nreq, g0;
    logic        ready, redir, gnt_en, last_req;
    logic [31:0] redir_pc, exp_fetch, last_addr;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic step();
        pend_t r;
        logic  is_pop;
        chk("sb_valid", 32'(instr_valid_o), 32'(expq.size() != 0));
        if (instr_valid_o && expq.size() != 0) begin
            chk("sb_pc", instr_pc_o, expq[0]);
            chk("sb_instr", instr_o, word_of(expq[0]));
        end
        redirect_i    = redir;
        redirect_pc_i = redir_pc;
        instr_ready_i = ready;
        mem_gnt_i     = gnt_en;
        if (pending.size() != 0 && pending[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = word_of(pending[0].addr);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 32'h0;
        end
        #1;
        last_req  = mem_req_o;
        last_addr = mem_addr_o;
        if (mem_req_o && mem_gnt_i) begin
            chk("fetch_addr", mem_addr_o, exp_fetch);
            pending.push_back('{addr: mem_addr_o, pc: exp_fetch, due: cyc + lat, stale: 1'b0});
            exp_fetch = exp_fetch + 32'd4;
            grants++;
            grants_since_rst++;
        end
        is_pop = instr_valid_o && instr_ready_i && !redir;
        if (is_pop) begin
            got_pc.push_back(instr_pc_o);
            if (expq.size() != 0) void'(expq.pop_front());
        end
        if (mem_rvalid_i) begin
            r = pending.pop_front();
            if (!r.stale && !redir) expq.push_back(r.pc);
        end
        if (redir) begin
            expq.delete();
            foreach (pending[i]) pending[i].stale = 1'b1;
            exp_fetch = redir_pc & ~32'h3;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic quiesce();
        ready  = 1'b1;
        redir  = 1'b0;
        gnt_en = 1'b0;
        for (int i = 0; i < 60 && (pending.size() != 0 || expq.size() != 0); i++) step();
        chk("quiesce_drained", 32'(pending.size() + expq.size()), 32'd0);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redir    = 1'b1;
        redir_pc = pc;
        step();
        redir    = 1'b0;
    endtask

    // Count request-free cycles before the next request (bounded).
    task automatic count_noreq(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (last_req) break;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; grants = 0; grants_since_rst = 0;
        ready = 1'b1; redir = 1'b0; redir_pc = 32'h0; gnt_en = 1'b1; lat = 1;
        exp_fetch = RESET_PC;
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; instr_ready_i = 1'b0;

        // Vector table: streaming with immediate grants and 1-cycle latency.
        for (int i = 0; i < 10; i++) begin
            tbl[i].ready     = 1'b1;
            tbl[i].exp_req   = (i >= 1);
            tbl[i].exp_addr  = (i >= 1) ? 32'(4 * (i - 1)) : RESET_PC;
            tbl[i].exp_valid = (i >= 3);
            tbl[i].exp_pc    = (i >= 3) ? 32'(4 * (i - 3)) : 32'h0;
        end

        #2 rst_i = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_addr", mem_addr_o, RESET_PC);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", instr_pc_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("tbl_valid", 32'(instr_valid_o), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk("tbl_pc", instr_pc_o, tbl[i].exp_pc);
                chk("tbl_instr", instr_o, word_of(tbl[i].exp_pc));
            end
            ready = tbl[i].ready;
            step();
            chk("tbl_req", 32'(last_req), 32'(tbl[i].exp_req));
            chk("tbl_addr", last_addr, tbl[i].exp_addr);
        end

        // Back-pressure: credits stop fetch at DEPTH words, release resumes it.
        quiesce();
        ready = 1'b0; gnt_en = 1'b1; lat = 1;
        redirect_to(32'h0000_1000);
        g0 = grants;
        repeat (10) step();
        chk("t2_grants", 32'(grants - g0), 32'(DEPTH));
        chk("t2_req_stalled", 32'(last_req), 32'd0);
        chk("t2_head_pc", instr_pc_o, 32'h0000_1000);
        got_pc.delete();
        ready = 1'b1;
        repeat (6) step();
        chk("t2_released", 32'(got_pc.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < got_pc.size(); k++)
            chk("t2_order", got_pc[k], 32'h0000_1000 + 32'(4 * k));
        chk("t2_resumed", 32'((grants - g0) > DEPTH), 32'd1);

        // Redirect with three responses in flight.
        quiesce();
        lat = 5; gnt_en = 1'b1; ready = 1'b1;
        redirect_to(32'h0000_2000);
        repeat (3) begin
            step();
            chk("t3_req", 32'(last_req), 32'd1);
        end
        redirect_to(32'h0000_0100);
        got_pc.delete();
        count_noreq(nreq);
        chk("t3_flush_len", 32'(nreq), 32'd4);
        chk("t3_addr", last_addr, 32'h0000_0100);
        repeat (10) step();
        chk("t3_first_pc", (got_pc.size() != 0) ? got_pc[0] : 32'hFFFF_FFFF, 32'h0000_0100);

        // Redirect coincident with a response and a pop.
        quiesce();
        lat = 2; gnt_en = 1'b1; ready = 1'b1;
        redirect_to(32'h0000_3000);
        repeat (3) step();
        chk("t4_valid_before", 32'(instr_valid_o), 32'd1);
        chk("t4_pc_before", instr_pc_o, 32'h0000_3000);
        redirect_to(32'h0000_0500);
        chk("t4_empty_after", 32'(instr_valid_o), 32'd0);
        got_pc.delete();
        count_noreq(nreq);
        chk("t4_flush_len", 32'(nreq), 32'd1);
        chk("t4_addr", last_addr, 32'h0000_0500);
        repeat (6) step();
        chk("t4_first_pc", (got_pc.size() != 0) ? got_pc[0] : 32'hFFFF_FFFF, 32'h0000_0500);

        // Unaligned redirect, then a second redirect while flushing.
        quiesce();
        lat = 3; gnt_en = 1'b1; ready = 1'b1;
        redirect_to(32'h0000_0203);
        step();
        chk("t5_align_req", 32'(last_req), 32'd1);
        chk("t5_align_addr", last_addr, 32'h0000_0200);
        step();
        redirect_to(32'h0000_0800);
        got_pc.delete();
        redirect_to(32'h0000_0400);
        count_noreq(nreq);
        chk("t5_flush_len", 32'(nreq), 32'd1);
        chk("t5_addr", last_addr, 32'h0000_0400);
        repeat (12) step();
        chk("t5_delivered", 32'(got_pc.size() != 0), 32'd1);
        foreach (got_pc[i]) chk("t5_pc", got_pc[i], 32'h0000_0400 + 32'(4 * i));

        // Asynchronous reset in the middle of a flush.
        quiesce();
        lat = 5; gnt_en = 1'b1; ready = 1'b1;
        redirect_to(32'h0000_3000);
        repeat (3) step();
        redirect_to(32'h0000_0600);
        step();
        #2 rst_i = 1'b0;
        #1;
        chk("t6_req", 32'(mem_req_o), 32'd0);
        chk("t6_valid", 32'(instr_valid_o), 32'd0);
        chk("t6_addr", mem_addr_o, RESET_PC);
        chk("t6_instr", instr_o, 32'h0);
        chk("t6_pc", instr_pc_o, 32'h0);
        pending.delete(); expq.delete(); got_pc.delete();
        exp_fetch = RESET_PC; grants_since_rst = 0;
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; redirect_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        step();
        chk("t6_boot_idle", 32'(last_req), 32'd0);
        step();
        chk("t6_refetch_req", 32'(last_req), 32'd1);
        chk("t6_refetch_addr", last_addr, RESET_PC);
        repeat (8) step();
        chk("t6_first_pc", (got_pc.size() != 0) ? got_pc[0] : 32'hFFFF_FFFF, RESET_PC);
`ifdef IFQ_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt_o, 32'(grants_since_rst));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch stage placed directly upstream of the single-cycle datapath. It replaces the direct program-counter-to-instruction-memory path.
- Issues word fetches to an instruction memory that has a request/grant handshake and in-order, variable-latency read responses.
- Buffers returned words with their PCs in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- A redirect (taken branch, jump or jr target) flushes the queue and discards responses already in flight.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding-plus-buffered words; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- redirect_i  in  1  flush the queue and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (forced to 0).
- mem_req_o  out  1  fetch request, combinational.
- mem_addr_o  out  32  word address of the request (= fetch_pc).
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; responses in grant order, at least 1 cycle after grant.
- mem_rdata_i  in  32  instruction word.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  head instruction.
- instr_pc_o  out  32  PC of the head instruction.
- instr_ready_i  in  1  decode consumes the head when valid and ready.

Behaviour:
- Registered state:
  - FSM {BOOT, RUN, FLUSH}
  - fetch_pc[31:0], resp_pc[31:0]
  - count, 0..DEPTH
  - outstanding, 0..DEPTH: granted but not yet returned
  - discard, 0..DEPTH
  - FIFO storage: {pc, instr}
- Reset (rst_i=0, asynchronous):
  - state=BOOT; fetch_pc=resp_pc=RESET_PC; count=outstanding=discard=0.
  - Outputs: mem_req_o=0, instr_valid_o=0, mem_addr_o=RESET_PC, instr_o=0, instr_pc_o=0.
  - Reset mid-operation abandons all in-flight responses; the memory side must be reset alongside.
- BOOT: one idle cycle after reset release, no request; then RUN.
- RUN:
  - mem_req_o = !redirect_i && (count+outstanding < DEPTH).
  - On req && gnt: fetch_pc += 4 (mod 2^32); outstanding += 1.
- Response in RUN with discard==0:
  - Push {resp_pc, mem_rdata_i}; resp_pc += 4; outstanding -= 1.
  - The credit rule guarantees space. Push and pop in the same cycle at count==DEPTH is legal.
- Pop: instr_valid_o && instr_ready_i && !redirect_i → count -= 1.
- Output timing: instr_valid_o = (count!=0). The FIFO head is registered, so push-to-valid latency is 1 cycle; an empty FIFO never bypasses.
- Redirect (highest priority, any state except BOOT):
  - count=0; fetch_pc = resp_pc = {redirect_pc_i[31:2], 2'b00}.
  - No request is issued that cycle. A pop in that cycle is void.
  - discard = outstanding − (mem_rvalid_i ? 1 : 0); a response arriving the same cycle is dropped.
  - outstanding is set equal to discard.
  - Next state: FLUSH if that value > 0, else RUN.
- FLUSH:
  - No requests.
  - Each mem_rvalid_i decrements discard and outstanding; data is dropped.
  - When discard reaches 0 → RUN.
  - A redirect while in FLUSH reapplies the redirect rule.
- Redirect in BOOT: latches the PC only; the BOOT→RUN transition still occurs.
- mem_rvalid_i with outstanding==0 is a protocol error: ignored; asserted in simulation.

Optional Feature:
- IFQ_PERF_CNT_EN
  - Defined: adds 32-bit outputs perf_fetch_cnt_o (grants accepted) and perf_flush_cnt_o (responses discarded). Both reset to 0, wrap at 2^32, increment in the cycle of the event.
  - Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared package:
  - FSM state typedef ifq_state_t {BOOT, RUN, FLUSH}
  - WORD_BYTES=4
  - localparam for the count width, $clog2(DEPTH+1)
- One sub-module: ifq_fifo. Synchronous DEPTH-entry FIFO of 64-bit {pc, instr} with push, pop and clear; clear has priority. The FSM, credit and discard logic stay in the top level.

Test Plan:
- Reset release, memory grants immediately with 1-cycle response, ready=1 → mem_addr_o 0,4,8,... from cycle 2; instr_pc_o 0,4,8 in order with matching data; no bubbles after fill.
- instr_ready_i=0, DEPTH=4, zero-latency grants → exactly 4 grants, then mem_req_o=0; count=4; raising ready releases 4 words in order and fetch resumes.
- 3 outstanding (latency 5), redirect to 0x100 → FLUSH; 3 responses dropped; next request addr 0x100; first delivered instr_pc_o=0x100.
- Redirect coincident with a response and a pop → response dropped, FIFO empty next cycle, discard = outstanding−1.
- redirect_pc_i=0x203 → fetch at 0x200; redirect again during FLUSH to 0x400 → only 0x400 words delivered.
- Async reset asserted mid-FLUSH → all outputs at reset values immediately; refetch starts at RESET_PC.
